host_link_arbiter: RTL and testbench
====================================

HOST_LINK_ARBITER -- requirements
Module: host_link_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
- els_p, default 4: number of requesters (1..16).
- width_p, default mc_fwd_width: packet width in bits.
- credits_p, default 8: link credits available after reset (1..64).
REQ-002 The block SHALL have the following ports (clock and reset first):
- clk_i  in  1: single clock for all logic.
- reset_i  in  1: synchronous, active-high reset.
- v_i  in  els_p: requester valid.
- data_i  in  els_p x width_p: requester packets.
- yumi_o  out  els_p: packet accepted this cycle.
- link_v_o  out  1: outbound link valid.
- link_data_o  out  width_p: outbound packet.
- link_token_i  in  1: one-cycle pulse, returns one credit.
- credits_o  out  clog2(credits_p+1): current credit count.
- error_o  out  1: sticky credit-overflow flag.

Function
REQ-003 The credit counter SHALL update once per cycle as follows:
- send only: decrement by 1.
- token only: increment by 1.
- send and token in the same cycle: unchanged.
REQ-004 The block SHALL grant only when credits_o is nonzero; a token arriving in the same cycle SHALL NOT enable a grant that cycle.
REQ-005 At most one yumi_o bit SHALL be high per cycle, only for a requester with v_i high, and only when REQ-004 allows a grant.
REQ-006 yumi_o SHALL be combinational from v_i and internal state; v_i SHALL NOT depend on yumi_o.
REQ-007 Arbitration SHALL be round-robin: the search starts at rr_ptr and rr_ptr becomes (winner+1) mod els_p after each grant; rr_ptr SHALL hold when no grant occurs.
REQ-008 The granted data_i SHALL appear on link_data_o, with link_v_o high, exactly one cycle after yumi_o (latency 1, registered output).
REQ-009 link_v_o SHALL be low in any cycle that does not follow a grant; link_data_o SHALL hold its last value when link_v_o is low.
REQ-010 Sustained throughput SHALL be one packet per cycle while credits remain and any v_i is high.
REQ-011 A token when credits_o equals credits_p with no send in the same cycle is an overflow: the counter SHALL hold and error_o SHALL set, and remain set until reset.
REQ-012 The counter SHALL never wrap below 0 or above credits_p.
REQ-013 els_p=1 SHALL degenerate to a credit-gated pass-through with rr_ptr held at 0.

Reset
REQ-014 While reset_i is high at a clock edge, the block SHALL set link_v_o=0, link_data_o=0, credits_o=credits_p, rr_ptr=0 and error_o=0.
REQ-015 yumi_o SHALL be all-zero while reset_i is high, and link_token_i SHALL be ignored.
REQ-016 A packet granted in the cycle before reset asserts SHALL be dropped, so that link_v_o is 0 in the cycle after the reset edge.

Configuration
REQ-017 The macro HOST_LINK_ARBITER_FIXED_PRIO_EN SHALL select the arbitration policy:
- defined: fixed priority, lowest index wins, and rr_ptr is removed.
- undefined: round-robin per REQ-007.
All other behaviour SHALL be identical in both builds.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Reset, then v_i=4'b1111 held for 4 cycles with no tokens -> yumi_o sequence 0001, 0010, 0100, 1000; link_v_o high on cycles 2-5; credits_o goes 8 to 4.
- credits_p=2, v_i=4'b0001 held -> exactly 2 yumi pulses, then yumi_o=0; one token pulse -> exactly one more yumi, issued the cycle after the token.
- credits_o=0, v_i high and token in the same cycle -> no yumi that cycle, yumi the next cycle; credits_o goes 0, 1, 0.
- credits_o=3, send and token in the same cycle -> credits_o stays 3.
- After reset (credits_o=8), one token pulse -> error_o=1 and credits_o stays 8; error_o persists until reset_i.
- Grant on cycle N with reset_i high on cycle N+1 -> link_v_o=0 on N+1 and N+2; credits_o=credits_p.
- Fixed-priority build with v_i=4'b1010 -> yumi_o=0010 every cycle while credits remain.

Source files
------------

// File: rtl/host_link_arbiter_if.sv
// Requester/link bundle for host_link_arbiter: master drives requests and tokens,
// slave returns grants, outbound packets, credit count and the sticky error flag.
interface host_link_arbiter_if #(
  parameter int els_p     = 4,
  parameter int width_p   = 32,
  parameter int credits_p = 8
);
  localparam int cw_lp = $clog2(credits_p + 1);

  logic [els_p-1:0]              v_i;
  logic [els_p-1:0][width_p-1:0] data_i;
  logic [els_p-1:0]              yumi_o;
  logic                          link_v_o;
  logic [width_p-1:0]            link_data_o;
  logic                          link_token_i;
  logic [cw_lp-1:0]              credits_o;
  logic                          error_o;

  modport master (
    output v_i, data_i, link_token_i,
    input  yumi_o, link_v_o, link_data_o, credits_o, error_o
  );

  modport slave (
    input  v_i, data_i, link_token_i,
    output yumi_o, link_v_o, link_data_o, credits_o, error_o
  );
endinterface

// File: rtl/host_link_arbiter.sv
// Credit-gated N:1 arbiter onto a host link; grant is combinational, packet is registered (latency 1),
// no grant while credits are zero. HOST_LINK_ARBITER_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module host_link_arbiter #(
  parameter int els_p     = 4,
  parameter int width_p   = 32,  // mc_fwd_width
  parameter int credits_p = 8
) (
  input logic                 clk_i,
  input logic                 reset_i,
  host_link_arbiter_if.slave  lnk
);
  localparam int cw_lp = $clog2(credits_p + 1);
  localparam int pw_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cw_lp-1:0] credits_max_lp = cw_lp'(credits_p);

  logic [cw_lp-1:0]   r_credits;
  logic               r_error;
  logic               r_link_v;
  logic [width_p-1:0] r_link_data;

  logic               w_can_grant;
  logic [els_p-1:0]   w_rot;
  logic [pw_lp-1:0]   w_off;
  logic               w_found;
  logic [pw_lp-1:0]   w_winner;
  logic [els_p-1:0]   w_yumi;

  // A token arriving this cycle only shows up in r_credits next cycle.
  assign w_can_grant = !reset_i && (r_credits != '0);

`ifdef HOST_LINK_ARBITER_FIXED_PRIO_EN
  assign w_rot    = lnk.v_i;
  assign w_winner = w_off;
`else
  localparam logic [pw_lp:0]   els_lp  = (pw_lp + 1)'(els_p);
  localparam logic [pw_lp-1:0] last_lp = pw_lp'(els_p - 1);

  logic [pw_lp-1:0]   r_rr_ptr;
  logic [2*els_p-1:0] w_dbl;
  logic [pw_lp:0]     w_sum;

  // Rotate requests so bit 0 is the requester at rr_ptr, then map the offset back.
  assign w_dbl    = {lnk.v_i, lnk.v_i} >> r_rr_ptr;
  assign w_rot    = w_dbl[els_p-1:0];
  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_winner = (w_sum >= els_lp) ? pw_lp'(w_sum - els_lp) : pw_lp'(w_sum);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (w_winner == last_lp) ? '0 : w_winner + 1'b1;
    end
  end
`endif

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < els_p; i++) begin
      if (w_can_grant && !w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = pw_lp'(i);
      end
    end
  end

  always_comb begin
    w_yumi = '0;
    for (int i = 0; i < els_p; i++) begin
      w_yumi[i] = w_found && (w_winner == pw_lp'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_credits   <= credits_max_lp;
      r_error     <= 1'b0;
      r_link_v    <= 1'b0;
      r_link_data <= '0;
    end else begin
      r_link_v <= w_found;
      if (w_found) begin
        r_link_data <= lnk.data_i[w_winner];
      end
      if (w_found && !lnk.link_token_i) begin
        r_credits <= r_credits - 1'b1;
      end else if (!w_found && lnk.link_token_i) begin
        if (r_credits == credits_max_lp) begin
          r_error <= 1'b1;
        end else begin
          r_credits <= r_credits + 1'b1;
        end
      end
    end
  end

  // Masking with reset drops a packet granted just before reset asserts.
  assign lnk.yumi_o      = w_yumi;
  assign lnk.link_v_o    = r_link_v & ~reset_i;
  assign lnk.link_data_o = r_link_data;
  assign lnk.credits_o   = r_credits;
  assign lnk.error_o     = r_error;
endmodule

// File: tb/tb_host_link_arbiter.sv
// Directed bench for host_link_arbiter: an 8-credit and a 2-credit instance, 4 requesters, 8-bit packets.
module tb_host_link_arbiter;
  logic clk;
  logic reset_i;
  int   tests;
  int   fails;

  host_link_arbiter_if #(.els_p(4), .width_p(8), .credits_p(8)) if1 ();
  host_link_arbiter_if #(.els_p(4), .width_p(8), .credits_p(2)) if2 ();

  host_link_arbiter #(.els_p(4), .width_p(8), .credits_p(8)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .lnk(if1)
  );
  host_link_arbiter #(.els_p(4), .width_p(8), .credits_p(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset_i), .lnk(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    if1.v_i = '0; if1.link_token_i = 1'b0;
    if2.v_i = '0; if2.link_token_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    if1.v_i = 4'b1111; if1.link_token_i = 1'b1;
    if1.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    #1;
    tests++;
    if (if1.yumi_o !== 4'b0000) begin
      fails++; $display("FAIL reset_yumi: got %b want 0000", if1.yumi_o);
    end
    step();
    #1;
    tests++;
    if (if1.credits_o !== 4'd8 || if1.link_v_o !== 1'b0 || if1.link_data_o !== 8'h00 || if1.error_o !== 1'b0) begin
      fails++; $display("FAIL reset_state: got cr=%0d lv=%b ld=%h err=%b want cr=8 lv=0 ld=00 err=0",
                        if1.credits_o, if1.link_v_o, if1.link_data_o, if1.error_o);
    end
    if1.link_token_i = 1'b0;
    if1.v_i = '0;
  endtask

  task automatic test_arbitration();
    logic [3:0] ey [5];
    logic [7:0] ed [5];
    logic       el [5];
    int         ec [5];
`ifdef HOST_LINK_ARBITER_FIXED_PRIO_EN
    ey = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    ed = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11};
`else
    ey = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    ed = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
    el = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ec = '{8, 7, 6, 5, 4};
    do_reset();
    if1.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    if1.v_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) if1.v_i = 4'b0000;
      #1;
      tests++;
      if (if1.yumi_o !== ey[c] || if1.link_v_o !== el[c] || int'(if1.credits_o) != ec[c] ||
          (el[c] && if1.link_data_o !== ed[c])) begin
        fails++;
        $display("FAIL arb_cycle%0d: got yumi=%b lv=%b ld=%h cr=%0d want yumi=%b lv=%b ld=%h cr=%0d",
                 c + 1, if1.yumi_o, if1.link_v_o, if1.link_data_o, if1.credits_o, ey[c], el[c], ed[c], ec[c]);
      end
      step();
    end
    #1;
    tests++;
    if (if1.link_v_o !== 1'b0 || if1.link_data_o !== ed[4] || if1.credits_o !== 4'd4) begin
      fails++; $display("FAIL arb_idle: got lv=%b ld=%h cr=%0d want lv=0 ld=%h cr=4",
                        if1.link_v_o, if1.link_data_o, if1.credits_o, ed[4]);
    end
  endtask

  task automatic test_credit_exhaust();
    logic [3:0] ey [7];
    int         ec [7];
    logic       tk [7];
    int         pulses;
    ey = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    ec = '{2, 1, 0, 0, 0, 1, 0};
    tk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    pulses = 0;
    do_reset();
    if2.data_i = {8'hD4, 8'hC3, 8'hB2, 8'hA5};
    if2.v_i = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      if2.link_token_i = tk[c];
      #1;
      if (if2.yumi_o != 4'b0000) pulses++;
      tests++;
      if (if2.yumi_o !== ey[c] || int'(if2.credits_o) != ec[c]) begin
        fails++; $display("FAIL credit_cycle%0d: got yumi=%b cr=%0d want yumi=%b cr=%0d",
                          c + 1, if2.yumi_o, if2.credits_o, ey[c], ec[c]);
      end
      step();
    end
    if2.link_token_i = 1'b0;
    if2.v_i = '0;
    tests++;
    if (pulses != 3) begin
      fails++; $display("FAIL credit_pulses: got %0d want 3", pulses);
    end
    tests++;
    if (if2.link_data_o !== 8'hA5) begin
      fails++; $display("FAIL credit_data: got %h want a5", if2.link_data_o);
    end
  endtask

  task automatic test_send_and_token();
    do_reset();
    if1.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    if1.v_i = 4'b0001;
    for (int c = 0; c < 5; c++) step();
    if1.link_token_i = 1'b1;
    #1;
    tests++;
    if (if1.credits_o !== 4'd3 || if1.yumi_o !== 4'b0001) begin
      fails++; $display("FAIL sendtok_pre: got cr=%0d yumi=%b want cr=3 yumi=0001", if1.credits_o, if1.yumi_o);
    end
    step();
    if1.link_token_i = 1'b0;
    if1.v_i = '0;
    #1;
    tests++;
    if (if1.credits_o !== 4'd3 || if1.link_v_o !== 1'b1) begin
      fails++; $display("FAIL sendtok_post: got cr=%0d lv=%b want cr=3 lv=1", if1.credits_o, if1.link_v_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    if1.link_token_i = 1'b1;
    #1;
    tests++;
    if (if1.error_o !== 1'b0) begin
      fails++; $display("FAIL ovf_before: got err=%b want 0", if1.error_o);
    end
    step();
    if1.link_token_i = 1'b0;
    #1;
    tests++;
    if (if1.error_o !== 1'b1 || if1.credits_o !== 4'd8) begin
      fails++; $display("FAIL ovf_set: got err=%b cr=%0d want err=1 cr=8", if1.error_o, if1.credits_o);
    end
    if1.v_i = 4'b0001;
    step();
    if1.v_i = '0;
    step();
    step();
    tests++;
    if (if1.error_o !== 1'b1 || if1.credits_o !== 4'd7) begin
      fails++; $display("FAIL ovf_sticky: got err=%b cr=%0d want err=1 cr=7", if1.error_o, if1.credits_o);
    end
    do_reset();
    #1;
    tests++;
    if (if1.error_o !== 1'b0 || if1.credits_o !== 4'd8) begin
      fails++; $display("FAIL ovf_clear: got err=%b cr=%0d want err=0 cr=8", if1.error_o, if1.credits_o);
    end
  endtask

  task automatic test_reset_drop();
    do_reset();
    if1.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    if1.v_i = 4'b0001;
    #1;
    tests++;
    if (if1.yumi_o !== 4'b0001) begin
      fails++; $display("FAIL drop_grant: got yumi=%b want 0001", if1.yumi_o);
    end
    step();
    reset_i = 1'b1;
    if1.v_i = '0;
    #1;
    tests++;
    if (if1.link_v_o !== 1'b0 || if1.yumi_o !== 4'b0000) begin
      fails++; $display("FAIL drop_n1: got lv=%b yumi=%b want lv=0 yumi=0000", if1.link_v_o, if1.yumi_o);
    end
    step();
    reset_i = 1'b0;
    #1;
    tests++;
    if (if1.link_v_o !== 1'b0 || if1.credits_o !== 4'd8) begin
      fails++; $display("FAIL drop_n2: got lv=%b cr=%0d want lv=0 cr=8", if1.link_v_o, if1.credits_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ey [4];
    logic [7:0] ed [4];
`ifdef HOST_LINK_ARBITER_FIXED_PRIO_EN
    ey = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
    ed = '{8'h00, 8'h22, 8'h22, 8'h22};
`else
    ey = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    ed = '{8'h00, 8'h22, 8'h44, 8'h22};
`endif
    do_reset();
    if1.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    if1.v_i = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (if1.yumi_o !== ey[c] || (c > 0 && (if1.link_v_o !== 1'b1 || if1.link_data_o !== ed[c]))) begin
        fails++; $display("FAIL b2b_cycle%0d: got yumi=%b lv=%b ld=%h want yumi=%b ld=%h",
                          c + 1, if1.yumi_o, if1.link_v_o, if1.link_data_o, ey[c], ed[c]);
      end
      step();
    end
    if1.v_i = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_i = 1'b1;
    if1.v_i = '0; if1.data_i = '0; if1.link_token_i = 1'b0;
    if2.v_i = '0; if2.data_i = '0; if2.link_token_i = 1'b0;
    test_reset();
    test_arbitration();
    test_credit_exhaust();
    test_send_and_token();
    test_overflow();
    test_reset_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
